// File: rtl/afc_freq_comparator.sv
// AFC frequency comparator: counts divided-VCO edges over a fixed reference window
// and issues a one-hot FAST/SLOW/FREEZE verdict with a one-cycle done strobe.
module afc_freq_comparator #(
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 64,
   parameter int CNT_W         = 16,
   parameter int TOL           = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fvco_div,
   input  logic [CNT_W-1:0] target_cnt,
   output logic [2:0]       comp_out,
   output logic             done,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             busy
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [WW-1:0]    WIN_LAST    = WW'(WIN_CYCLES - 1);
   localparam logic [CNT_W:0]   TOL_W       = (CNT_W + 1)'(TOL);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [2:0] V_FAST   = 3'b100;
   localparam logic [2:0] V_SLOW   = 3'b010;
   localparam logic [2:0] V_FREEZE = 3'b001;
   localparam logic [2:0] V_NONE   = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_COMPARE = 3'd3,
      ST_REPORT  = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic             s1_r;
   logic             s2_r;
   logic             s3_r;
   logic             rise_s;
   logic [SW-1:0]    settle_cnt_r;
   logic [WW-1:0]    win_cnt_r;
   logic             settle_last_s;
   logic             win_last_s;
   logic [CNT_W-1:0] edge_cnt_r;
   logic [CNT_W-1:0] target_r;
   logic [CNT_W-1:0] meas_cnt_r;
   logic [CNT_W:0]   cnt_ext_s;
   logic [CNT_W:0]   tgt_ext_s;
   logic [CNT_W:0]   hi_s;
   logic [CNT_W:0]   lo_s;
   logic [2:0]       verdict_s;
   logic [2:0]       comp_out_r;
   logic [2:0]       comp_nx_s;
   logic             done_r;
   logic             busy_r;
   logic             busy_nx_s;

   assign rise_s        = s2_r & ~s3_r;
   assign settle_last_s = (settle_cnt_r == SETTLE_LAST);
   assign win_last_s    = (win_cnt_r == WIN_LAST);

   assign comp_out = comp_out_r;
   assign done     = done_r;
   assign meas_cnt = meas_cnt_r;
   assign busy     = busy_r;

   // Verdict from the finished window count; lo saturates at zero.
   always_comb begin
      cnt_ext_s = {1'b0, edge_cnt_r};
      tgt_ext_s = {1'b0, target_r};
      hi_s      = tgt_ext_s + TOL_W;
      if (tgt_ext_s >= TOL_W) begin
         lo_s = tgt_ext_s - TOL_W;
      end else begin
         lo_s = {(CNT_W + 1){1'b0}};
      end
      if (cnt_ext_s > hi_s) begin
         verdict_s = V_FAST;
      end else if (cnt_ext_s < lo_s) begin
         verdict_s = V_SLOW;
      end else begin
         verdict_s = V_FREEZE;
      end
   end

   // Next-state logic; enable low aborts to IDLE from every state.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nx_s = ST_SETTLE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!enable) begin
               state_nx_s = ST_IDLE;
            end else if (settle_last_s) begin
               state_nx_s = ST_MEASURE;
            end else begin
               state_nx_s = ST_SETTLE;
            end
         end
         ST_MEASURE: begin
            if (!enable) begin
               state_nx_s = ST_IDLE;
            end else if (win_last_s) begin
               state_nx_s = ST_COMPARE;
            end else begin
               state_nx_s = ST_MEASURE;
            end
         end
         ST_COMPARE: begin
            if (!enable) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (!enable) begin
               state_nx_s = ST_IDLE;
            end else if (comp_out_r == V_FREEZE) begin
               state_nx_s = ST_HALT;
            end else begin
               state_nx_s = ST_SETTLE;
            end
         end
         ST_HALT: begin
            if (!enable) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, decoded from the state being entered.
   always_comb begin
      comp_nx_s = V_NONE;
      busy_nx_s = 1'b0;
      case (state_nx_s)
         ST_REPORT: begin
            comp_nx_s = verdict_s;
            busy_nx_s = 1'b1;
         end
         ST_HALT: begin
            comp_nx_s = comp_out_r;
            busy_nx_s = 1'b0;
         end
         ST_SETTLE, ST_MEASURE, ST_COMPARE: begin
            comp_nx_s = V_NONE;
            busy_nx_s = 1'b1;
         end
         default: begin
            comp_nx_s = V_NONE;
            busy_nx_s = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Synchroniser and history flop for fvco_div; free-running in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= fvco_div;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Settle and window cycle counters; each restarts at zero on entry to its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt_r <= {SW{1'b0}};
         win_cnt_r    <= {WW{1'b0}};
      end else begin
         if ((state_r == ST_SETTLE) && (state_nx_s == ST_SETTLE)) begin
            settle_cnt_r <= settle_cnt_r + {{(SW - 1){1'b0}}, 1'b1};
         end else begin
            settle_cnt_r <= {SW{1'b0}};
         end
         if ((state_r == ST_MEASURE) && (state_nx_s == ST_MEASURE)) begin
            win_cnt_r <= win_cnt_r + {{(WW - 1){1'b0}}, 1'b1};
         end else begin
            win_cnt_r <= {WW{1'b0}};
         end
      end
   end

   // Saturating edge counter and target latch, both armed on entry to MEASURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_r <= {CNT_W{1'b0}};
         target_r   <= {CNT_W{1'b0}};
      end else if ((state_r == ST_SETTLE) && (state_nx_s == ST_MEASURE)) begin
         edge_cnt_r <= {CNT_W{1'b0}};
         target_r   <= target_cnt;
      end else if ((state_r == ST_MEASURE) && rise_s && (edge_cnt_r != CNT_MAX)) begin
         edge_cnt_r <= edge_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
      end else begin
         edge_cnt_r <= edge_cnt_r;
      end
   end

   // Registered outputs; done and a fresh meas_cnt only when REPORT is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         comp_out_r <= V_NONE;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         meas_cnt_r <= {CNT_W{1'b0}};
      end else begin
         comp_out_r <= comp_nx_s;
         done_r     <= (state_nx_s == ST_REPORT);
         busy_r     <= busy_nx_s;
         if (state_nx_s == ST_REPORT) begin
            meas_cnt_r <= edge_cnt_r;
         end else begin
            meas_cnt_r <= meas_cnt_r;
         end
      end
   end

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Self-checking bench for afc_freq_comparator: directed test-plan steps plus
// randomized windows checked against an arithmetic reference model.
module tb_afc_freq_comparator;

   localparam int W   = 100;
   localparam int S   = 10;
   localparam int CW  = 16;
   localparam int TL  = 2;
   localparam int LAT = S + W + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          fvco_div;
   logic [CW-1:0] target_cnt;
   logic [2:0]    comp_out;
   logic          done;
   logic [CW-1:0] meas_cnt;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int per = 0;
   int pulse_goal = 0;
   int pulses_sent = 0;

   afc_freq_comparator #(
      .WIN_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(CW), .TOL(TL)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .fvco_div(fvco_div),
      .target_cnt(target_cnt), .comp_out(comp_out), .done(done),
      .meas_cnt(meas_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // VCO model: periodic when per>0, otherwise emits queued single-cycle pulses.
   initial begin
      int ph;
      ph = 0;
      fvco_div = 1'b0;
      forever begin
         @(negedge clk);
         if (per != 0) begin
            ph = (ph + 1) % per;
            fvco_div = (ph < per / 2);
         end else if (fvco_div) begin
            fvco_div = 1'b0;
         end else if (pulses_sent < pulse_goal) begin
            fvco_div = 1'b1;
            pulses_sent++;
         end else begin
            fvco_div = 1'b0;
         end
      end
   end

   function automatic logic [2:0] ref_verdict(input int cnt, input int tgt);
      int hi;
      int lo;
      hi = tgt + TL;
      lo = (tgt - TL < 0) ? 0 : tgt - TL;
      if (cnt > hi) return 3'b100;
      if (cnt < lo) return 3'b010;
      return 3'b001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int limit, output int lat);
      bit found;
      found = 1'b0;
      lat = -1;
      for (int k = 1; k <= limit && !found; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            found = 1'b1;
            lat = k;
         end
      end
   endtask

   task automatic count_dones(input int n, output int nd);
      nd = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
   endtask

   task automatic periodic_run(input int p, input int t);
      int lat;
      per = p;
      target_cnt = CW'(t);
      enable = 1'b1;
      wait_done(LAT + 20, lat);
      chk("per_lat", 32'(lat), 32'(LAT));
      chk("per_comp", 32'(comp_out), 32'(ref_verdict(W / p, t)));
      chk("per_meas", 32'(meas_cnt), 32'(W / p));
      enable = 1'b0;
      @(negedge clk);
      chk("per_idle_comp", 32'(comp_out), 32'd0);
      chk("per_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic pulse_run(input int n, input int t);
      int lat;
      per = 0;
      target_cnt = CW'(t);
      enable = 1'b1;
      repeat (30) @(negedge clk);
      pulse_goal = pulse_goal + n;
      wait_done(LAT, lat);
      chk("pls_lat", 32'(lat), 32'(LAT - 30));
      chk("pls_comp", 32'(comp_out), 32'(ref_verdict(n, t)));
      chk("pls_meas", 32'(meas_cnt), 32'(n));
      enable = 1'b0;
      @(negedge clk);
      chk("pls_idle_comp", 32'(comp_out), 32'd0);
      chk("pls_idle_meas", 32'(meas_cnt), 32'(n));
   endtask

   initial begin
      int lat;
      int nd;
      int pers[5] = '{2, 4, 5, 10, 20};
      int pcnt[4] = '{27, 28, 23, 22};
      rst = 1'b1;
      enable = 1'b0;
      target_cnt = '0;
      repeat (3) @(negedge clk);
      chk("rst_comp", 32'(comp_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_meas", 32'(meas_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: on-target frequency freezes and halts
      per = 4;
      target_cnt = 16'd25;
      enable = 1'b1;
      wait_done(LAT + 20, lat);
      chk("t1_lat", 32'(lat), 32'(LAT));
      chk("t1_comp", 32'(comp_out), 32'b001);
      chk("t1_meas", 32'(meas_cnt), 32'd25);
      chk("t1_busy_rep", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_halt_busy", 32'(busy), 32'd0);
      chk("t1_halt_done", 32'(done), 32'd0);
      chk("t1_halt_comp", 32'(comp_out), 32'b001);
      count_dones(150, nd);
      chk("t1_no_done", 32'(nd), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      chk("t1_idle_comp", 32'(comp_out), 32'd0);

      // Test 2: fast VCO keeps iterating with period S+W+2
      per = 2;
      enable = 1'b1;
      wait_done(LAT + 20, lat);
      chk("t2_lat", 32'(lat), 32'(LAT));
      chk("t2_comp", 32'(comp_out), 32'b100);
      chk("t2_meas", 32'(meas_cnt), 32'd50);
      wait_done(LAT + 20, lat);
      chk("t2_period", 32'(lat), 32'(LAT));
      chk("t2_comp2", 32'(comp_out), 32'b100);
      @(negedge clk);
      chk("t2_after_comp", 32'(comp_out), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_idle_meas", 32'(meas_cnt), 32'd50);

      // Test 3: slow, then corrected during SETTLE
      per = 5;
      enable = 1'b1;
      wait_done(LAT + 20, lat);
      chk("t3_lat", 32'(lat), 32'(LAT));
      chk("t3_comp", 32'(comp_out), 32'b010);
      chk("t3_meas", 32'(meas_cnt), 32'd20);
      @(negedge clk);
      per = 4;
      wait_done(LAT + 20, lat);
      chk("t3_lat2", 32'(lat), 32'(LAT - 1));
      chk("t3_comp2", 32'(comp_out), 32'b001);
      chk("t3_meas2", 32'(meas_cnt), 32'd25);
      @(negedge clk);
      chk("t3_halt_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      @(negedge clk);

      // Test 4: exact pulse counts around the dead band
      for (int i = 0; i < 4; i++) pulse_run(pcnt[i], 25);

      // Abort mid-window: no done, meas_cnt kept
      per = 4;
      target_cnt = 16'd25;
      enable = 1'b1;
      repeat (60) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_comp", 32'(comp_out), 32'd0);
      count_dones(150, nd);
      chk("abort_no_done", 32'(nd), 32'd0);
      chk("abort_meas", 32'(meas_cnt), 32'd22);

      // Test 5: reset mid-window
      enable = 1'b1;
      count_dones(S + 50, nd);
      chk("t5_no_done", 32'(nd), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_comp", 32'(comp_out), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_meas", 32'(meas_cnt), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_done(LAT + 20, lat);
      chk("t5_lat", 32'(lat), 32'(LAT));
      chk("t5_comp2", 32'(comp_out), 32'b001);
      chk("t5_meas2", 32'(meas_cnt), 32'd25);
      enable = 1'b0;
      @(negedge clk);

      // Test 6: target 1, no VCO edges -> lo saturates, FREEZE
      per = 0;
      target_cnt = 16'd1;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      wait_done(LAT + 20, lat);
      chk("t6_lat", 32'(lat), 32'(LAT));
      chk("t6_comp", 32'(comp_out), 32'b001);
      chk("t6_meas", 32'(meas_cnt), 32'd0);
      @(negedge clk);
      chk("t6_halt_comp", 32'(comp_out), 32'b001);
      enable = 1'b0;
      @(negedge clk);
      chk("t6_idle_comp", 32'(comp_out), 32'd0);

      // Randomized windows against the reference model
      for (int i = 0; i < 6; i++) begin
         periodic_run(pers[$urandom_range(0, 4)], int'($urandom_range(0, 60)));
      end
      for (int i = 0; i < 6; i++) begin
         pulse_run(int'($urandom_range(0, 30)), int'($urandom_range(0, 35)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/afc_freq_comparator.md
# afc_freq_comparator

Measurement front end of the automatic frequency calibration loop. Counts rising edges of the divided VCO clock over a fixed window of reference (`clk`) cycles and compares the count against a programmable target. It produces the one-hot verdict (`FAST`=100, `SLOW`=010, `FREEZE`=001) and a one-cycle `done` strobe that drive the binary-search band-select FSM directly downstream. Between verdicts it inserts a settle interval so the VCO can settle after each band change.

## Interface
- `WIN_CYCLES`, default 1024: measurement window length in `clk` cycles; must be ≥1.
- `SETTLE_CYCLES`, default 64: settle wait before each window; must be ≥1.
- `CNT_W`, default 16: width of the edge counter and the target.
- `TOL`, default 2: ± dead band, in counts, that yields `FREEZE`.
- `clk` input 1: reference clock, the only clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: level. High runs calibration; low aborts and idles.
- `fvco_div` input 1: divided VCO clock, asynchronous to `clk`.
- `target_cnt` input CNT_W: expected edge count per window; sampled on entry to MEASURE.
- `comp_out` output 3: verdict, one-hot; 000 when no verdict is held.
- `done` output 1: one-cycle strobe; `comp_out` is valid in the same cycle.
- `meas_cnt` output CNT_W: last completed window count, held until the next COMPARE.
- `busy` output 1: high in every state except IDLE and HALT.

## Operation
- Synchroniser: two flops (`s1`, `s2`) plus a history flop `s3`. A rising edge is `s2 & ~s3`.
  - Edges are counted only in MEASURE.
  - The synchroniser runs in every state, so there is no startup glitch on entering MEASURE.
- States: IDLE, SETTLE, MEASURE, COMPARE, REPORT, HALT.
- IDLE: `enable`=1 → SETTLE. Settle counter loads 0; `comp_out` is 000.
- SETTLE: counts SETTLE_CYCLES cycles, then → MEASURE. On entry to MEASURE:
  - edge counter clears;
  - window counter clears;
  - `target_cnt` is latched.
- MEASURE: runs exactly WIN_CYCLES cycles. The edge counter increments per detected edge and saturates at 2^CNT_W−1 (no wrap). Then → COMPARE.
- COMPARE: one cycle, arithmetic in CNT_W+1 bits.
  - `hi` = target + TOL.
  - `lo` = target − TOL, saturated at 0.
  - count > `hi` → FAST; count < `lo` → SLOW; otherwise FREEZE. Boundaries `lo` and `hi` themselves yield FREEZE.
  - `meas_cnt` is updated. The verdict is registered into `comp_out` → REPORT.
- REPORT: `done`=1 for exactly this cycle.
  - Verdict FREEZE → HALT.
  - Otherwise → SETTLE. `comp_out` returns to 000 on leaving REPORT.
- HALT: `done`=0. `comp_out` holds 001 and `meas_cnt` holds. Leaves only on `enable`=0 → IDLE (`comp_out`→000) or on `rst`.
- `enable`=0 in any state other than IDLE aborts to IDLE on the next edge:
  - no `done` is issued;
  - `comp_out` → 000;
  - `meas_cnt` keeps its last value.
- `enable` falling in the REPORT cycle: `done` still asserts in that cycle, then the block goes to IDLE.
- The downstream FSM samples `done`/`comp_in` on the same edge, so its band update lands during our SETTLE. No handshake back is required.

## Timing
- Reset, sampled on a `clk` edge with `rst`=1, takes priority over everything. All of the following are zero: state=IDLE, `comp_out`=000, `done`=0, `meas_cnt`=0, `busy`=0, all counters, synchroniser flops.
- `rst` asserted mid-window: the window is discarded, the block is in IDLE the next cycle, and no `done` is issued.
- Latency: the edge sampling `enable`=1 in IDLE is edge 0.
  - SETTLE occupies cycles 1..S.
  - MEASURE occupies cycles S+1..S+W.
  - COMPARE is cycle S+W+1.
  - `done` is high in cycle S+W+2.
- Verdict period while iterating: S+W+2 cycles, with the next `done` S+W+2 cycles after the previous one.
- Edge detection lags `fvco_div` by 2–3 `clk` cycles. This offset is constant and accepted. `fvco_div` must be below `clk`/2.
- `busy` is registered with the state: 1 from cycle 1 through the REPORT cycle, then 0 in HALT/IDLE.

## Test plan
All tests use WIN_CYCLES=100, SETTLE_CYCLES=10, TOL=2, target_cnt=25.
1. `fvco_div` period 4 `clk` (25 edges/window), `enable` rises → `done` in cycle 112 with `comp_out`=001, `meas_cnt`=25. Then HALT, `busy`=0, no further `done`.
2. Period 2 (50 edges) → `done` with `comp_out`=100, `meas_cnt`=50. Next `done` 112 cycles later, again 100.
3. Period 5 (20 edges) → 010. Then switch to period 4 during SETTLE → next `done` gives 001 and HALT.
4. Inject exactly 27, 28, 23, 22 pulses in successive windows → verdicts 001, 100, 001, 010.
5. Assert `rst` at window cycle 50, release, keep `enable` high → all outputs 0 the cycle after reset. First `done` 112 cycles after release with a fresh count; no stale verdict.
6. target_cnt=1, no VCO edges → `lo` saturates at 0, `comp_out`=001. `enable` low in HALT → IDLE, `comp_out`=000 next cycle.
